// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store encodings, LSU state type and request legality check
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // High when the request must be answered with an error and never touch memory.
    function automatic logic lsu_req_bad(input logic we, input logic [2:0] f3, input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (we) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// rtl/lsu_byte_align.sv - combinational load extraction/extension and store lane merge
module lsu_byte_align
    import riscv_pkg::*;
(
    input  logic [31:0] buf_word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane i of the buffer lives in bits [8i+7:8i], so a right shift brings the target lane down.
    assign byte_shift = buf_word >> {addr_lo, 3'b000};
    assign half_shift = buf_word >> {addr_lo[1], 4'b0000};
    assign sel_byte   = byte_shift[7:0];
    assign sel_half   = half_shift[15:0];

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = buf_word;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        store_word = buf_word;
        case (funct3)
            F3_B:    store_word[{addr_lo, 3'b000} +: 8]      = wdata[7:0];
            F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_word = wdata;
            default: store_word = buf_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - single-outstanding load/store unit with read-modify-write sub-word stores
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [31:0]     resp_rdata,
    output logic [31:0]     mem_addr,
    input  logic [0:3][7:0] mem_data_out,
    output logic [0:3][7:0] mem_data_in,
    output logic            mem_write_en
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    lsu_state_t    state;
    lsu_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic          err_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   buf_q;
    logic [31:0]   mem_word;
    logic [31:0]   load_data;
    logic [31:0]   store_word;
    logic          accept;
    logic          req_bad;
    logic          read_done;

    assign accept    = req_valid && (state == IDLE);
    assign req_bad   = lsu_req_bad(req_we, req_funct3, req_addr[1:0]);
    assign read_done = (state == READ) && (cnt == '0);
    assign mem_word  = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nxt = RESP;
                    end else if (!req_we) begin
                        state_nxt = READ;
                    end else if (req_funct3 == F3_W) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = we_q ? WRITE : RESP;
                end
            end
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, latency counter and read buffer; the counter is preloaded on accept.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt     <= '0;
            buf_q   <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_bad;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= CNT_LOAD;
            end else if ((state == READ) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (read_done) begin
                buf_q <= mem_word;
            end
        end
    end

    lsu_byte_align u_align (
        .buf_word   (buf_q),
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_err     = (state == RESP) && err_q;
    assign resp_rdata   = ((state == RESP) && !err_q && !we_q) ? load_data : 32'h0;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_write_en = (state == WRITE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_in[i] = mem_write_en ? store_word[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu at latencies 1 and 4 against a byte-array model
module tb_riscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        req_valid;
    logic        sel;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic            rv1, rdy1, rsv1, rse1, mwe1;
    logic            rv4, rdy4, rsv4, rse4, mwe4;
    logic [31:0]     rd1, ma1, rd4, ma4;
    logic [0:3][7:0] mdo1, mdi1, mdo4, mdi4;

    logic            cur_ready, cur_rv, cur_err, cur_we;
    logic [31:0]     cur_rdata, cur_ma;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    logic [31:0] last1, last4;
    int          stab1, stab4;

    assign rv1 = req_valid & ~sel;
    assign rv4 = req_valid & sel;

    riscv_lsu #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsv1), .resp_err(rse1), .resp_rdata(rd1), .mem_addr(ma1),
        .mem_data_out(mdo1), .mem_data_in(mdi1), .mem_write_en(mwe1)
    );

    riscv_lsu #(.MEM_LATENCY(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv4), .req_ready(rdy4), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsv4), .resp_err(rse4), .resp_rdata(rd4), .mem_addr(ma4),
        .mem_data_out(mdo4), .mem_data_in(mdi4), .mem_write_en(mwe4)
    );

    assign cur_ready = sel ? rdy4 : rdy1;
    assign cur_rv    = sel ? rsv4 : rsv1;
    assign cur_err   = sel ? rse4 : rse1;
    assign cur_we    = sel ? mwe4 : mwe1;
    assign cur_rdata = sel ? rd4  : rd1;
    assign cur_ma    = sel ? ma4  : ma1;

    // Memory model: data is only valid once the word address has been held for the latency; earlier reads return scrambled bytes.
    always @(negedge clk) begin
        stab1 <= (ma1 == last1) ? stab1 + 1 : 1;
        last1 <= ma1;
        stab4 <= (ma4 == last4) ? stab4 + 1 : 1;
        last4 <= ma4;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mdo1[i] = mem[{ma1[9:2], 2'b00} + i];
            if (!((ma1 == last1) && (stab1 >= 1))) mdo1[i] = mdo1[i] ^ 8'h5A;
            mdo4[i] = mem[{ma4[9:2], 2'b00} + i];
            if (!((ma4 == last4) && (stab4 >= 4))) mdo4[i] = mdo4[i] ^ 8'h5A;
        end
    end

    always @(posedge clk) begin
        if (mwe1) for (int i = 0; i < 4; i++) mem[{ma1[9:2], 2'b00} + i] = mdi1[i];
        if (mwe4) for (int i = 0; i < 4; i++) mem[{ma4[9:2], 2'b00} + i] = mdi4[i];
    end

    task automatic set_byte(input int a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Drives one request and observes until the response (bounded to 20 cycles; lat = -1 if none).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd, output int wp,
                          output logic [31:0] ma_seen);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; wp = 0; err = 1'b0; rd = 32'h0; ma_seen = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            if (cur_we) wp++;
            if (cur_rv) begin
                lat = c; err = cur_err; rd = cur_rdata; ma_seen = cur_ma;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference: architectural effect of one request on ref_mem, from the ISA rules.
    task automatic ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
        int sz;
        logic legal;
        int b;
        logic [31:0] v;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        sz  = 1 << f3[1:0];
        err = !legal || ((a % sz) != 0);
        rd  = 32'h0;
        b   = int'(a[9:0]);
        if (!err) begin
            if (we) begin
                for (int k = 0; k < sz; k++) ref_mem[b + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[b + k]) << (8 * k));
                if (!f3[2] && sz < 4 && v[8*sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0; req_valid = 1'b0; sel = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_tests++; if ({rdy1, rdy4} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b want=11", {rdy1, rdy4}); end
        n_tests++; if ({rsv1, rsv4, rse1, rse4} !== 4'b0) begin n_fail++; $display("FAIL reset_resp got=%b want=0000", {rsv1, rsv4, rse1, rse4}); end
        n_tests++; if ((rd1 | rd4) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h want=0", rd1, rd4); end
        n_tests++; if ((ma1 | ma4) !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h/%h want=0", ma1, ma4); end
        n_tests++; if ({mdi1, mdi4, mwe1, mwe4} !== 66'h0) begin n_fail++; $display("FAIL reset_mem_write got=%h/%h we=%b%b want=0", mdi1, mdi4, mwe1, mwe4); end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb;
        int lat; logic err; logic [31:0] rd; int wp; logic [31:0] ma;
        sel = 1'b0;
        set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22); set_byte(32'h102, 8'h83); set_byte(32'h103, 8'h44);
        do_req(1'b0, 3'd0, 32'h102, 32'h0, lat, err, rd, wp, ma);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency got=%0d want=2", lat); end
        n_tests++; if (rd !== 32'hFFFFFF83 || err !== 1'b0) begin n_fail++; $display("FAIL lb_rdata got=%h err=%b want=ffffff83", rd, err); end
        n_tests++; if (ma !== 32'h100) begin n_fail++; $display("FAIL lb_mem_addr got=%h want=00000100", ma); end
        do_req(1'b0, 3'd4, 32'h102, 32'h0, lat, err, rd, wp, ma);
        n_tests++; if (rd !== 32'h00000083 || lat !== 2) begin n_fail++; $display("FAIL lbu_rdata got=%h lat=%0d want=00000083 lat=2", rd, lat); end
    endtask

    task automatic test_sh_rmw;
        int lat; logic err; logic [31:0] rd; int wp; logic [31:0] ma;
        logic [31:0] got;
        sel = 1'b0;
        set_byte(32'h104, 8'h01); set_byte(32'h105, 8'h02); set_byte(32'h106, 8'h03); set_byte(32'h107, 8'h04);
        do_req(1'b1, 3'd1, 32'h106, 32'hAAAABEEF, lat, err, rd, wp, ma);
        got = {mem[32'h107], mem[32'h106], mem[32'h105], mem[32'h104]};
        n_tests++; if (wp !== 1) begin n_fail++; $display("FAIL sh_write_pulses got=%0d want=1", wp); end
        n_tests++; if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sh_resp got lat=%0d err=%b rd=%h want lat=3 err=0 rd=0", lat, err, rd); end
        n_tests++; if (got !== 32'hBEEF0201) begin n_fail++; $display("FAIL sh_merge got=%h want=beef0201", got); end
        ref_mem[32'h106] = 8'hEF; ref_mem[32'h107] = 8'hBE;
    endtask

    task automatic test_misaligned;
        int lat; logic err; logic [31:0] rd; int wp; logic [31:0] ma;
        sel = 1'b0;
        do_req(1'b0, 3'd2, 32'h101, 32'h0, lat, err, rd, wp, ma);
        n_tests++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned got lat=%0d err=%b want lat=1 err=1", lat, err); end
        n_tests++; if (rd !== 32'h0 || wp !== 0) begin n_fail++; $display("FAIL lw_misaligned_side got rd=%h wp=%0d want rd=0 wp=0", rd, wp); end
        do_req(1'b0, 3'd3, 32'h100, 32'h0, lat, err, rd, wp, ma);
        n_tests++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL load_f3_3 got lat=%0d err=%b want lat=1 err=1", lat, err); end
        do_req(1'b1, 3'd4, 32'h100, 32'h12345678, lat, err, rd, wp, ma);
        n_tests++; if (lat !== 1 || err !== 1'b1 || wp !== 0) begin n_fail++; $display("FAIL store_f3_4 got lat=%0d err=%b wp=%0d want 1 1 0", lat, err, wp); end
        do_req(1'b1, 3'd1, 32'h103, 32'h12345678, lat, err, rd, wp, ma);
        n_tests++; if (lat !== 1 || err !== 1'b1 || wp !== 0) begin n_fail++; $display("FAIL sh_misaligned got lat=%0d err=%b wp=%0d want 1 1 0", lat, err, wp); end
    endtask

    task automatic test_latency;
        int lat2;
        sel = 1'b1;
        set_byte(32'h200, 8'hEF); set_byte(32'h201, 8'hBE); set_byte(32'h202, 8'hAD); set_byte(32'h203, 8'hDE);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_funct3 = 3'd4; req_addr = 32'h201;
        for (int c = 1; c <= 6; c++) begin
            n_tests++; if (cur_ready !== (c == 6)) begin n_fail++; $display("FAIL lat4_ready cycle=%0d got=%b want=%b", c, cur_ready, c == 6); end
            n_tests++; if (cur_rv !== (c == 5)) begin n_fail++; $display("FAIL lat4_resp_valid cycle=%0d got=%b want=%b", c, cur_rv, c == 5); end
            if (c == 5) begin
                n_tests++; if (cur_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat4_rdata got=%h want=deadbeef", cur_rdata); end
            end
            if (c < 6) @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 12; c++) begin
            if (cur_rv) begin
                lat2 = c;
                n_tests++; if (cur_rdata !== 32'h000000BE) begin n_fail++; $display("FAIL lat4_held_rdata got=%h want=000000be", cur_rdata); end
                break;
            end
            @(negedge clk);
        end
        n_tests++; if (lat2 !== 5) begin n_fail++; $display("FAIL lat4_held_latency got=%0d want=5", lat2); end
    endtask

    task automatic test_reset_mid_store;
        int bad;
        sel = 1'b0;
        set_byte(32'h108, 8'h10); set_byte(32'h109, 8'h20); set_byte(32'h10A, 8'h30); set_byte(32'h10B, 8'h40);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h109; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (mwe1 !== 1'b1) begin n_fail++; $display("FAIL rst_store_write_cycle got=%b want=1", mwe1); end
        #1 rst_b = 1'b0;
        #1;
        n_tests++; if (mwe1 !== 1'b0) begin n_fail++; $display("FAIL rst_async_we_drop got=%b want=0", mwe1); end
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsv1 !== 1'b0 || rdy1 !== 1'b1) bad++;
            @(negedge clk);
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rst_no_response bad_cycles=%0d want=0", bad); end
        n_tests++; if (mem[32'h109] !== 8'h20) begin n_fail++; $display("FAIL rst_no_write got=%h want=20", mem[32'h109]); end
    endtask

    task automatic test_random;
        int lat, exp_lat, wp, lmem;
        logic err, exp_err, we;
        logic [31:0] rd, exp_rd, a, wd, ma;
        logic [2:0] f3;
        int mism;
        for (int n = 0; n < 1000; n++) begin
            sel = 1'($urandom % 2);
            we  = 1'($urandom % 2);
            f3  = 3'($urandom % 8);
            a   = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            wd  = $urandom;
            lmem = sel ? 4 : 1;
            ref_exec(we, f3, a, wd, exp_err, exp_rd);
            if (exp_err)          exp_lat = 1;
            else if (!we)         exp_lat = lmem + 1;
            else if (f3 == 3'd2)  exp_lat = 2;
            else                  exp_lat = lmem + 2;
            do_req(we, f3, a, wd, lat, err, rd, wp, ma);
            n_tests++;
            if (lat !== exp_lat || err !== exp_err || rd !== exp_rd) begin
                n_fail++;
                $display("FAIL random_%0d we=%b f3=%0d a=%h got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                         n, we, f3, a, lat, err, rd, exp_lat, exp_err, exp_rd);
            end
        end
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        n_tests++; if (mism !== 0) begin n_fail++; $display("FAIL random_memory_image mismatched_bytes=%0d want=0", mism); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset;
        test_lb;
        test_sh_rmw;
        test_misaligned;
        test_latency;
        test_reset_mid_store;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the RISC-V core's execute stage and the byte-lane data memory. Accepts one load or store request at a time and performs the word-aligned memory access. Loads are sign- or zero-extended; sub-word stores use read-modify-write. Misaligned or illegal requests return an error response and never reach memory.

## Interface
- MEM_LATENCY, 1: cycles from a stable `mem_addr` to valid `mem_data_out`; legal values are 1 or more.
- clk  input  1  clock; everything is rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU idle; the request is accepted on an edge where both `req_valid` and `req_ready` are high.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the load/store.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (rs2).
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  misaligned or illegal request; qualified by `resp_valid`.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_data_out  input  8x[0:3]  read bytes; lane i holds byte at `mem_addr`+i.
- mem_data_in  output  8x[0:3]  write bytes, same lane order.
- mem_write_en  output  1  writes all four lanes at the rising edge.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - READ: wait MEM_LATENCY cycles.
  - WRITE: single cycle.
  - RESP: single cycle.
- On accept, latch we, funct3, addr and wdata.
- Legal loads: funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal stores: 0 SB, 1 SH, 2 SW. Anything else is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Transitions from IDLE:
  - Illegal or misaligned goes to RESP with `resp_err`=1. No memory cycle is issued.
  - Load goes to READ, then RESP.
  - SW goes to WRITE, then RESP.
  - SB/SH goes to READ, then WRITE, then RESP.
- RESP always returns to IDLE.
- READ loads a down-counter with MEM_LATENCY−1. On the counter's last cycle, capture `mem_data_out` into a 32-bit buffer.
- Load extraction from the buffer:
  - Byte lane = addr[1:0].
  - Halfword lanes = {addr[1],0} and {addr[1],1}, little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store merge:
  - SB replaces lane addr[1:0] with wdata[7:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW drives all lanes from wdata.
  - Non-targeted lanes come from the buffer.
- `mem_write_en`=1 only in WRITE. `mem_data_in` holds the merged word during WRITE.
- `mem_addr` is driven from the latched address in every state. It is stable throughout READ and WRITE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_addr`=0, `mem_data_in`=all 0, `mem_write_en`=0, buffer 0.
- Taking the accept edge as cycle 0, `resp_valid` is high in these cycles:
  - Error: cycle 1.
  - SW: cycle 2 (WRITE in cycle 1).
  - Load: cycle MEM_LATENCY+1.
  - SB/SH: cycle MEM_LATENCY+2.
- `req_ready` is low from cycle 1 through the RESP cycle. It is high again in the cycle after RESP, so back-to-back throughput is one request per (latency+1) cycles.
- A request held on `req_valid` while `req_ready`=0 is ignored and must be held by the core.
- Reset asserted mid-operation:
  - The LSU returns to IDLE immediately.
  - `mem_write_en` drops asynchronously.
  - No response is ever produced for the aborted request.
- `resp_rdata` and `resp_err` are driven only in RESP and are 0 otherwise.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - `lsu_state_t` enum {IDLE, READ, WRITE, RESP}.
- Sub-module `lsu_byte_align`: purely combinational. It takes buffer, funct3, addr[1:0] and wdata, and produces the extended load data and the merged store lanes. It has its own unit bench.
- The top level holds the FSM, the latency counter, the request latches and the buffer.

## Test plan
- **LB sign-extend:** MEM_LATENCY=1, memory word at 0x100 = bytes {0x11,0x22,0x83,0x44}; LB addr 0x102 → `resp_valid` at cycle 2, `resp_rdata`=0xFFFFFF83, `mem_addr`=0x100. Repeat with LBU → 0x00000083.
- **SH read-modify-write:** SH addr 0x106, wdata 0xAAAABEEF over word {0x01,0x02,0x03,0x04} → single `mem_write_en` pulse with lanes {0x01,0x02,0xEF,0xBE}; `resp_valid` at cycle 3.
- **Misaligned:** LW addr 0x101 → `resp_err`=1 at cycle 1, `mem_write_en` never asserted, `resp_rdata`=0. Also funct3=3 load → `resp_err`=1.
- **Latency sweep:** MEM_LATENCY=4, LW 0x200 (data 0xDEADBEEF) → `resp_valid` exactly at cycle 5; `req_ready`=0 during cycles 1–5; a second request held meanwhile is accepted at cycle 6.
- **Reset mid-store:** assert `rst_b`=0 during the WRITE cycle of SB → `mem_write_en` falls before the next edge, no `resp_valid` pulse, `req_ready`=1 after release.
- **Random self-check:** 1000 random legal/illegal requests against a byte-array reference model → all responses and the final memory image match.
